// File: rtl/serial_pkg.sv
// Shared serial-path types: byte type and default buffer depth used by the
// transmitter, the receiver and the transmit FIFO.
package serial_pkg;

    localparam int UartDataWidth    = 8;
    localparam int UartFifoDepthDef = 16;

    typedef logic [UartDataWidth-1:0] uart_byte_t;

endpackage

// File: rtl/serial_tx_fifo_if.sv
// Core-side write strobe plus transmitter-side data/send/ready handshake,
// bundled so the FIFO, its producer and its transmitter share one port.
interface serial_tx_fifo_if
    import serial_pkg::*;
#(
    parameter int Depth = UartFifoDepthDef
);
    localparam int CountWidth = $clog2(Depth) + 1;

    logic                  iWrite;
    uart_byte_t            iData;
    logic                  oFull;
    logic [CountWidth-1:0] oCount;
    logic                  oOverflow;
    uart_byte_t            oData;
    logic                  oSend;
    logic                  iReady;

    // FIFO side
    modport slave (
        input  iWrite, iData, iReady,
        output oFull, oCount, oOverflow, oData, oSend
    );

    // Producer / transmitter side
    modport master (
        output iWrite, iData, iReady,
        input  oFull, oCount, oOverflow, oData, oSend
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// First-word-fall-through byte queue feeding the serial transmitter. Every
// output is derived from registered state, so nothing combinational runs
// from iWrite or iReady to the outputs.
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int Depth = UartFifoDepthDef
) (
    input  logic             iClock,
    input  logic             iReset,
    serial_tx_fifo_if.slave  bus
);
    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = PtrWidth + 1;
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    uart_byte_t            mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CountWidth-1:0] count;
    logic                  overflow;
    logic                  full;
    logic                  send;
    logic                  push;
    logic                  pop;

    // Full/empty come from the count, never from pointer equality.
    assign full = (count == FullCount);
    assign send = (count != '0);

    // A write while full is dropped even if a pop happens on the same edge.
    assign push = bus.iWrite & ~full;
    assign pop  = send & bus.iReady;

    // Pointer, count and sticky overflow state; reset discards the queue.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.iWrite && full) overflow <= 1'b1;
        end
    end

    // Storage write port; contents need no reset.
    always_ff @(posedge iClock) begin
        if (push) mem[wr_ptr] <= bus.iData;
    end

    assign bus.oData     = mem[rd_ptr];
    assign bus.oSend     = send;
    assign bus.oFull     = full;
    assign bus.oCount    = count;
    assign bus.oOverflow = overflow;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Scoreboard bench: accepted bytes are queued on write and compared against
// oData on every pop; level outputs are compared against the queue model.
module tb_serial_tx_fifo;
    import serial_pkg::*;

    localparam int DEPTH = 16;

    logic iClock = 1'b0;
    logic iReset = 1'b1;

    serial_tx_fifo_if #(.Depth(DEPTH)) bus ();

    serial_tx_fifo #(.Depth(DEPTH)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus.slave)
    );

    always #5 iClock = ~iClock;

    uart_byte_t exp_q[$];
    logic       exp_ovf = 1'b0;
    int         n_chk   = 0;
    int         n_pass  = 0;
    int         busy    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    // One clock: drive inputs, check levels and any pop before the edge,
    // then advance the model as the edge will.
    task automatic cyc(input logic w, input uart_byte_t d, input logic r, input logic rst,
                       output logic popped);
        uart_byte_t head;
        logic       was_full;
        bus.iWrite = w;
        bus.iData  = d;
        bus.iReady = r;
        iReset     = rst;
        popped     = 1'b0;
        @(negedge iClock);
        chk("count", 32'(bus.oCount), 32'(exp_q.size()));
        chk("full",  32'(bus.oFull),  32'(exp_q.size() == DEPTH));
        chk("send",  32'(bus.oSend),  32'(exp_q.size() != 0));
        chk("ovf",   32'(bus.oOverflow), 32'(exp_ovf));
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            was_full = (exp_q.size() == DEPTH);
            if (r && exp_q.size() != 0) begin
                head = exp_q.pop_front();
                chk("data", 32'(bus.oData), 32'(head));
                popped = 1'b1;
            end
            if (w) begin
                if (was_full) exp_ovf = 1'b1;
                else          exp_q.push_back(d);
            end
        end
        @(posedge iClock);
        #1;
    endtask

    // Writes n bytes base, base+1, ... on consecutive cycles while a
    // transmitter model pops and then stays busy for a frame's worth of
    // cycles; keeps going until the queue drains or the budget runs out.
    task automatic run(input int n, input uart_byte_t base, input int budget);
        logic p;
        int   i;
        i = 0;
        while ((i < n || exp_q.size() != 0) && i < budget) begin
            cyc(i < n, base + uart_byte_t'(i), busy == 0, 1'b0, p);
            if (p)            busy = 9;
            else if (busy > 0) busy--;
            i++;
        end
        if (i >= budget) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        busy = 0;
    endtask

    initial begin
        logic p;
        bus.iWrite = 1'b0;
        bus.iData  = '0;
        bus.iReady = 1'b0;

        // Reset for two cycles, then idle with ready high: nothing pops
        iReset = 1'b1;
        repeat (2) @(posedge iClock);
        #1;
        iReset = 1'b0;
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0, p);

        // Single byte, ready held high: visible next cycle, popped after
        cyc(1'b1, 8'h55, 1'b1, 1'b0, p);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, p);
        chk("single_pop", 32'(p), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, p);

        // Burst of 0x01..0x08 drained by the transmitter model
        run(8, 8'h01, 400);

        // Fill with ready low: 17 writes, the last one dropped
        for (int i = 0; i < 17; i++) cyc(1'b1, uart_byte_t'(i), 1'b0, 1'b0, p);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, p);
        chk("fill_ovf", 32'(bus.oOverflow), 32'd1);
        // Write while full and popping on the same edge is still dropped
        reset_free_full_pop();
        run(0, 8'h00, 400);

        // Simultaneous push/pop at count=1
        cyc(1'b1, 8'hA0, 1'b0, 1'b0, p);
        cyc(1'b1, 8'hB1, 1'b1, 1'b0, p);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, p);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, p);

        // Reset during a pop cycle with 5 bytes queued
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + uart_byte_t'(i), 1'b0, 1'b0, p);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, p);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0, p);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, p);
        chk("post_reset_pop", 32'(p), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, p);

        // Ragged write pattern across pointer wrap
        for (int i = 0; i < 40; i++)
            cyc(($urandom_range(0, 2) != 0), uart_byte_t'($urandom), ($urandom_range(0, 1) != 0), 1'b0, p);
        run(0, 8'h00, 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Queue is full: top up to full if needed, then write and pop together.
    task automatic reset_free_full_pop();
        logic p;
        while (exp_q.size() < DEPTH) cyc(1'b1, 8'h77, 1'b0, 1'b0, p);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, p);
        chk("full_pop_len", 32'(exp_q.size()), 32'(DEPTH - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
